// File: rtl/store_chk_pkg.sv
// Shared definitions for the store sequence checker: FSM encoding and
// the width of the RUN cycle counter.
package store_chk_pkg;

  localparam int CYCLE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_e;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store table: DEPTH entries of {address, data}, one synchronous
// write port cleared by reset and one combinational read port.
module store_exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Writes to indices beyond DEPTH are silently dropped.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (we && (int'(wr_idx) < DEPTH)) begin
      addr_d[wr_idx] = wr_addr;
      data_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    if (int'(rd_idx) < DEPTH) begin
      rd_addr = addr_q[rd_idx];
      rd_data = data_q[rd_idx];
    end
  end

endmodule

// File: rtl/store_sequence_checker.sv
// Run-status monitor: watches the CPU data-memory write bus and checks for an
// ordered sequence of expected stores, reporting pass, fail or timeout.
module store_sequence_checker
  import store_chk_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int STRICT  = 1,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [IDX_W-1:0]   prog_idx,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0]  prog_data,
  input  logic [IDX_W:0]     num_exp,
  input  logic               ign_en,
  input  logic [ADDR_W-1:0]  ign_addr,
  input  logic               start,
  input  logic               memwrite,
  input  logic [ADDR_W-1:0]  dataadr,
  input  logic [DATA_W-1:0]  writedata,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [IDX_W:0]     match_cnt,
  output logic [CYCLE_W-1:0] cycle
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W:0]     num_exp_q, num_exp_d;
  logic [IDX_W:0]     match_cnt_q, match_cnt_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;

  logic [ADDR_W-1:0]  exp_addr;
  logic [DATA_W-1:0]  exp_data;
  logic               hit, ignored, last_entry, num_exp_ok;

  store_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (prog_we && (state_q == ST_IDLE)),
    .wr_idx  (prog_idx),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_idx  (ptr_q),
    .rd_addr (exp_addr),
    .rd_data (exp_data)
  );

  assign hit        = (dataadr == exp_addr) && (writedata == exp_data);
  assign ignored    = ign_en && (dataadr == ign_addr);
  assign last_entry = ({1'b0, ptr_q} == (num_exp_q - 1'b1));
  assign num_exp_ok = (num_exp != '0) && (int'(num_exp) <= DEPTH);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    num_exp_d   = num_exp_q;
    match_cnt_d = match_cnt_q;
    cycle_d     = cycle_q;
    fail_idx_d  = fail_idx_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
        if (start) begin
          ptr_d       = '0;
          match_cnt_d = '0;
          cycle_d     = '0;
          num_exp_d   = num_exp;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          if (num_exp_ok) begin
            state_d = ST_RUN;
            fail_d  = 1'b0;
            done_d  = 1'b0;
          end else begin
            state_d    = ST_FAIL;
            fail_d     = 1'b1;
            done_d     = 1'b1;
            fail_idx_d = '0;
          end
        end
      end

      ST_RUN: begin
        if (cycle_q != '1) begin
          cycle_d = cycle_q + 1'b1;
        end
        if (memwrite) begin
          if (hit) begin
            ptr_d       = ptr_q + 1'b1;
            match_cnt_d = match_cnt_q + 1'b1;
            if (last_entry) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
              done_d  = 1'b1;
            end
          end else if (!ignored && (STRICT != 0)) begin
            state_d    = ST_FAIL;
            fail_d     = 1'b1;
            done_d     = 1'b1;
            fail_idx_d = ptr_q;
          end
        end
        // A pass or fail on the final RUN edge takes precedence over timeout.
        if ((state_d == ST_RUN) && (cycle_q == CYCLE_W'(TIMEOUT - 1))) begin
          state_d   = ST_TMO;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      num_exp_q   <= '0;
      match_cnt_q <= '0;
      cycle_q     <= '0;
      fail_idx_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      num_exp_q   <= num_exp_d;
      match_cnt_q <= match_cnt_d;
      cycle_q     <= cycle_d;
      fail_idx_q  <= fail_idx_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_idx  = fail_idx_q;
  assign match_cnt = match_cnt_q;
  assign cycle     = cycle_q;

endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench for store_sequence_checker: a STRICT=1 and a STRICT=0
// instance share one stimulus stream; expected values are hand-computed.
module tb_store_sequence_checker;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_we;
  logic [1:0]        prog_idx;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [2:0]        num_exp;
  logic              ign_en;
  logic [ADDR_W-1:0] ign_addr;
  logic              start;
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  logic        done, pass, fail, timeout;
  logic [1:0]  fail_idx;
  logic [2:0]  match_cnt;
  logic [31:0] cycle;

  logic        ns_done, ns_pass, ns_fail, ns_timeout;
  logic [1:0]  ns_fail_idx;
  logic [2:0]  ns_match_cnt;
  logic [31:0] ns_cycle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_sequence_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1)
  ) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_addr(prog_addr), .prog_data(prog_data), .num_exp(num_exp),
    .ign_en(ign_en), .ign_addr(ign_addr), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_idx(fail_idx), .match_cnt(match_cnt),
    .cycle(cycle)
  );

  store_sequence_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(0)
  ) dut_ns (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_addr(prog_addr), .prog_data(prog_data), .num_exp(num_exp),
    .ign_en(ign_en), .ign_addr(ign_addr), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .done(ns_done), .pass(ns_pass),
    .fail(ns_fail), .timeout(ns_timeout), .fail_idx(ns_fail_idx),
    .match_cnt(ns_match_cnt), .cycle(ns_cycle)
  );

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic programEntry(input logic [1:0] idx, input logic [31:0] addr,
                              input logic [31:0] data);
    prog_we   = 1'b1;
    prog_idx  = idx;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic startRun(input logic [2:0] n);
    num_exp = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    num_exp = 3'd7;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    memwrite  = 1'b1;
    dataadr   = addr;
    writedata = data;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_fail"}, 64'(fail), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_fail_idx"}, 64'(fail_idx), 64'd0);
    checkOutput({tag, "_match_cnt"}, 64'(match_cnt), 64'd0);
    checkOutput({tag, "_cycle"}, 64'(cycle), 64'd0);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_addr = '0; prog_data = '0;
    num_exp = '0; ign_en = 1'b1; ign_addr = 32'd80; start = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;

    doReset();
    checkAllZero("reset");

    // Single-entry run with an ignored scratch store first.
    programEntry(2'd0, 32'd84, 32'd7);
    startRun(3'd1);
    applyStimulus(32'd80, 32'd3);
    checkOutput("ign_no_done", 64'(done), 64'd0);
    applyStimulus(32'd84, 32'd7);
    checkOutput("one_pass", 64'(pass), 64'd1);
    checkOutput("one_done", 64'(done), 64'd1);
    checkOutput("one_match_cnt", 64'(match_cnt), 64'd1);
    checkOutput("one_fail", 64'(fail), 64'd0);
    checkOutput("one_cycle", 64'(cycle), 64'd2);

    // Unexpected store: STRICT instance fails, relaxed one keeps going.
    startRun(3'd1);
    applyStimulus(32'd88, 32'd5);
    checkOutput("strict_fail", 64'(fail), 64'd1);
    checkOutput("strict_fail_idx", 64'(fail_idx), 64'd0);
    checkOutput("strict_match_cnt", 64'(match_cnt), 64'd0);
    checkOutput("strict_pass", 64'(pass), 64'd0);
    checkOutput("relaxed_running", 64'(ns_done), 64'd0);
    applyStimulus(32'd84, 32'd7);
    checkOutput("relaxed_pass", 64'(ns_pass), 64'd1);
    checkOutput("relaxed_fail", 64'(ns_fail), 64'd0);
    checkOutput("relaxed_match_cnt", 64'(ns_match_cnt), 64'd1);
    checkOutput("strict_fail_hold", 64'(fail), 64'd1);

    // Three-entry in-order sequence.
    doReset();
    programEntry(2'd0, 32'h40, 32'd1);
    programEntry(2'd1, 32'h44, 32'd2);
    programEntry(2'd2, 32'h48, 32'd3);
    startRun(3'd3);
    applyStimulus(32'h40, 32'd1);
    applyStimulus(32'h44, 32'd2);
    checkOutput("seq_mid_cnt", 64'(match_cnt), 64'd2);
    checkOutput("seq_mid_pass", 64'(pass), 64'd0);
    applyStimulus(32'h48, 32'd3);
    checkOutput("seq_pass", 64'(pass), 64'd1);
    checkOutput("seq_match_cnt", 64'(match_cnt), 64'd3);
    checkOutput("seq_cycle", 64'(cycle), 64'd3);

    // Restart after PASS with the retained table and replay.
    startRun(3'd3);
    checkOutput("rerun_cnt_clr", 64'(match_cnt), 64'd0);
    checkOutput("rerun_cycle_clr", 64'(cycle), 64'd0);
    checkOutput("rerun_pass_clr", 64'(pass), 64'd0);
    checkOutput("rerun_done_clr", 64'(done), 64'd0);
    applyStimulus(32'h40, 32'd1);
    applyStimulus(32'h44, 32'd2);
    applyStimulus(32'h48, 32'd3);
    checkOutput("rerun_pass", 64'(pass), 64'd1);
    checkOutput("rerun_cycle", 64'(cycle), 64'd3);

    // Out-of-order store fails at entry 0.
    startRun(3'd3);
    applyStimulus(32'h44, 32'd2);
    checkOutput("ooo_fail", 64'(fail), 64'd1);
    checkOutput("ooo_fail_idx", 64'(fail_idx), 64'd0);

    // prog_we outside IDLE must not alter the table; then fail at entry 1.
    programEntry(2'd0, 32'h99, 32'd9);
    startRun(3'd3);
    applyStimulus(32'h40, 32'd1);
    checkOutput("prog_ignored_cnt", 64'(match_cnt), 64'd1);
    applyStimulus(32'h48, 32'd3);
    checkOutput("skip_fail", 64'(fail), 64'd1);
    checkOutput("skip_fail_idx", 64'(fail_idx), 64'd1);
    checkOutput("skip_match_cnt", 64'(match_cnt), 64'd1);

    // Timeout with no stores: declared on the 20th RUN edge.
    startRun(3'd3);
    idleCycles(TIMEOUT - 1);
    checkOutput("tmo_before", 64'(timeout), 64'd0);
    checkOutput("tmo_before_cycle", 64'(cycle), 64'd19);
    tick();
    checkOutput("tmo_flag", 64'(timeout), 64'd1);
    checkOutput("tmo_done", 64'(done), 64'd1);
    checkOutput("tmo_cycle", 64'(cycle), 64'd20);
    checkOutput("tmo_pass", 64'(pass), 64'd0);
    checkOutput("tmo_fail", 64'(fail), 64'd0);

    // Final match on the timeout edge wins.
    startRun(3'd3);
    applyStimulus(32'h40, 32'd1);
    applyStimulus(32'h44, 32'd2);
    idleCycles(17);
    checkOutput("late_cycle", 64'(cycle), 64'd19);
    applyStimulus(32'h48, 32'd3);
    checkOutput("late_pass", 64'(pass), 64'd1);
    checkOutput("late_timeout", 64'(timeout), 64'd0);
    checkOutput("late_cycle_end", 64'(cycle), 64'd20);

    // Reset mid-run clears everything, including the table.
    startRun(3'd3);
    applyStimulus(32'h40, 32'd1);
    checkOutput("pre_reset_cnt", 64'(match_cnt), 64'd1);
    doReset();
    checkAllZero("midrun_reset");
    startRun(3'd0);
    checkOutput("nexp0_fail", 64'(fail), 64'd1);
    checkOutput("nexp0_fail_idx", 64'(fail_idx), 64'd0);
    checkOutput("nexp0_done", 64'(done), 64'd1);
    startRun(3'd5);
    checkOutput("nexp5_fail", 64'(fail), 64'd1);
    startRun(3'd1);
    checkOutput("nexp1_running", 64'(done), 64'd0);
    applyStimulus(32'd0, 32'd0);
    checkOutput("zeroed_table_pass", 64'(pass), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
